// File: rtl/uart_rx_pkg.sv
// Shared definitions for the parametrised UART receiver.
//   state_t        receiver FSM states
//   MIN_PRESCALE   smallest usable oversampling ratio; smaller Prescale
//                  values are raised to this
//   MAX_DATA_WIDTH widest payload supported, used to size parity input
//   maj3()         majority of three samples
//   parity_calc()  expected parity bit for a payload (odd=1 -> odd parity)
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } state_t;

  localparam int MIN_PRESCALE   = 6;
  localparam int MAX_DATA_WIDTH = 9;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic parity_calc(input logic [MAX_DATA_WIDTH-1:0] data,
                                       input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-timing engine for the UART receiver.
// Counts edge_cnt 0..prescale-1 across each bit period while run is high
// and captures the line at mid-1, mid and mid+1 (mid = prescale>>1).
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   run         count while high; counter is held at 0 otherwise
//   rx_s        synchronised serial line
//   prescale    effective cycles per bit (already clamped by the caller)
//   bit_end     edge_cnt is at the last cycle of the bit period
//   bit_tick    edge_cnt is at mid+1; bit_val is valid this cycle
//   bit_val     majority of the three samples
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      run,
  input  logic                      rx_s,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      bit_end,
  output logic                      bit_tick,
  output logic                      bit_val
);

  localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);

  logic [PRESCALE_WIDTH-1:0] edge_cnt;
  logic [PRESCALE_WIDTH-1:0] mid;
  logic                      samp_a;
  logic                      samp_b;

  assign mid      = prescale >> 1;
  assign bit_end  = (edge_cnt == prescale - ONE);
  assign bit_tick = (edge_cnt == mid + ONE);
  // Third sample is taken live from rx_s so the vote resolves at mid+1.
  assign bit_val  = maj3(samp_a, samp_b, rx_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
      samp_a   <= 1'b1;
      samp_b   <= 1'b1;
    end else if (!run) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= bit_end ? '0 : edge_cnt + ONE;
      if (edge_cnt == mid - ONE) samp_a <= rx_s;
      if (edge_cnt == mid)       samp_b <= rx_s;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable payload width, oversampling,
// optional parity and one or two stop bits, 3-sample majority recovery.
// Ports:
//   CLK, RST    clock and asynchronous active-low reset
//   RX_IN       asynchronous serial line, idle high
//   Prescale    cycles per bit (values below MIN_PRESCALE act as MIN_PRESCALE)
//   PAR_EN      parity bit present
//   PAR_TYP     0 even, 1 odd
//   STOP2       two stop bits required
//   P_DATA      last good payload, LSB received first
//   data_valid  one-cycle pulse when P_DATA is updated
//   par_err     one-cycle pulse on parity mismatch
//   stp_err     one-cycle pulse when any stop bit sampled low
// Configuration inputs are captured when a start edge is accepted, so they
// may change freely while a frame is in flight.
module uart_rx_param
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      STOP2,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      stp_err
);

  localparam int                        BCW      = $clog2(DATA_WIDTH);
  localparam logic [PRESCALE_WIDTH-1:0] MIN_P    = PRESCALE_WIDTH'(MIN_PRESCALE);
  localparam logic [BCW-1:0]            LAST_BIT = BCW'(DATA_WIDTH - 1);
  localparam logic [BCW-1:0]            CNT_ONE  = BCW'(1);

  logic [SYNC_STAGES-1:0]    sync_q;
  logic                      rx_s;
  logic                      rx_prev;
  logic                      fall;

  state_t                    state;
  state_t                    state_nxt;

  logic [PRESCALE_WIDTH-1:0] p_lat;
  logic                      par_en_lat;
  logic                      par_typ_lat;
  logic                      stop2_lat;

  logic [BCW-1:0]            bit_cnt;
  logic [DATA_WIDTH-1:0]     shift_reg;
  logic [MAX_DATA_WIDTH-1:0] data_ext;
  logic                      par_bad;
  logic                      stp_bad;

  logic                      run;
  logic                      start_acc;
  logic                      shift_en;
  logic                      par_chk;
  logic                      stp_chk;
  logic                      frame_done;
  logic                      last_data;
  logic                      last_stop;

  logic                      bit_end;
  logic                      bit_tick;
  logic                      bit_val;

  // Input synchroniser, idle-high so reset does not look like a start edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q  <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], RX_IN};
      rx_prev <= rx_s;
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign fall = rx_prev & ~rx_s;

  uart_rx_sampler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_sampler (
    .clk     (CLK),
    .rst_n   (RST),
    .run     (run),
    .rx_s    (rx_s),
    .prescale(p_lat),
    .bit_end (bit_end),
    .bit_tick(bit_tick),
    .bit_val (bit_val)
  );

  assign last_data = (bit_cnt == LAST_BIT);
  assign last_stop = (bit_cnt == {{(BCW-1){1'b0}}, stop2_lat});

  always_comb begin
    data_ext                 = '0;
    data_ext[DATA_WIDTH-1:0] = shift_reg;
  end

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic. DONE also accepts a start edge: at the minimum
  // prescale the next start bit begins in the DONE cycle itself.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (fall) state_nxt = START;
      START: begin
        if (bit_tick && bit_val) state_nxt = IDLE;
        else if (bit_end)        state_nxt = DATA;
      end
      DATA:   if (bit_end && last_data) state_nxt = par_en_lat ? PARITY : STOP;
      PARITY: if (bit_end) state_nxt = STOP;
      STOP:   if (bit_tick && last_stop) state_nxt = DONE;
      DONE:   state_nxt = fall ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode.
  always_comb begin
    run        = 1'b0;
    start_acc  = 1'b0;
    shift_en   = 1'b0;
    par_chk    = 1'b0;
    stp_chk    = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE:   start_acc = fall;
      START:  run = 1'b1;
      DATA: begin
        run      = 1'b1;
        shift_en = bit_tick;
      end
      PARITY: begin
        run     = 1'b1;
        par_chk = bit_tick;
      end
      STOP: begin
        run     = 1'b1;
        stp_chk = bit_tick;
      end
      DONE: begin
        start_acc  = fall;
        frame_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Payload shifter; contents only matter once a full frame is in.
  always_ff @(posedge CLK) begin
    if (shift_en) shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      p_lat       <= MIN_P;
      par_en_lat  <= 1'b0;
      par_typ_lat <= 1'b0;
      stop2_lat   <= 1'b0;
      bit_cnt     <= '0;
      par_bad     <= 1'b0;
      stp_bad     <= 1'b0;
      P_DATA      <= '0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;

      if (start_acc) begin
        p_lat       <= (Prescale < MIN_P) ? MIN_P : Prescale;
        par_en_lat  <= PAR_EN;
        par_typ_lat <= PAR_TYP;
        stop2_lat   <= STOP2;
        bit_cnt     <= '0;
        par_bad     <= 1'b0;
        stp_bad     <= 1'b0;
      end else begin
        // bit_cnt indexes data bits in DATA, then stop bits in STOP.
        if (state == DATA && bit_end) bit_cnt <= last_data ? '0 : bit_cnt + CNT_ONE;
        if (state == STOP && bit_end) bit_cnt <= bit_cnt + CNT_ONE;
        if (par_chk) par_bad <= (bit_val != parity_calc(data_ext, par_typ_lat));
        if (stp_chk && !bit_val) stp_bad <= 1'b1;
      end

      // Error flags are read here before any same-cycle clear above lands.
      if (frame_done) begin
        if (!par_bad && !stp_bad) begin
          P_DATA     <= shift_reg;
          data_valid <= 1'b1;
        end
        par_err <= par_bad;
        stp_err <= stp_bad;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: one 8-bit and one 5-bit instance,
// directed frames plus randomised frames compared against a frame-level
// outcome model (good frame -> new data, otherwise error flags with held data).
module tb_uart_rx_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       line;
  logic       use5;
  logic       rx8;
  logic       rx5;
  logic [5:0] pre_in;
  logic       pen_in;
  logic       ptyp_in;
  logic       s2_in;

  logic [7:0] pd8;
  logic       dv8, pe8, se8;
  logic [4:0] pd5;
  logic       dv5, pe5, se5;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] obs8[$];
  logic [31:0] obs5[$];
  logic [8:0]  lg8;
  logic [8:0]  lg5;

  always #5 clk = ~clk;

  assign rx8 = use5 ? 1'b1 : line;
  assign rx5 = use5 ? line : 1'b1;

  uart_rx_param #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6), .SYNC_STAGES(2)) dut8 (
    .CLK(clk), .RST(rst_n), .RX_IN(rx8), .Prescale(pre_in), .PAR_EN(pen_in),
    .PAR_TYP(ptyp_in), .STOP2(s2_in), .P_DATA(pd8), .data_valid(dv8),
    .par_err(pe8), .stp_err(se8));

  uart_rx_param #(.DATA_WIDTH(5), .PRESCALE_WIDTH(6), .SYNC_STAGES(2)) dut5 (
    .CLK(clk), .RST(rst_n), .RX_IN(rx5), .Prescale(pre_in), .PAR_EN(pen_in),
    .PAR_TYP(ptyp_in), .STOP2(s2_in), .P_DATA(pd5), .data_valid(dv5),
    .par_err(pe5), .stp_err(se5));

  function automatic logic [31:0] ev(input logic dv, input logic pe,
                                     input logic se, input logic [8:0] d);
    return {20'd0, dv, pe, se, d};
  endfunction

  // Every cycle with any pulse becomes one observed event.
  always @(negedge clk) begin
    if (dv8 | pe8 | se8) obs8.push_back(ev(dv8, pe8, se8, {1'b0, pd8}));
    if (dv5 | pe5 | se5) obs5.push_back(ev(dv5, pe5, se5, {4'd0, pd5}));
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic flush(input string tag);
    logic [31:0] o;
    logic [31:0] e;
    int          n_obs;
    repeat (20) @(negedge clk);
    n_obs = use5 ? obs5.size() : obs8.size();
    chk({tag, ".count"}, 32'(n_obs), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = 32'hDEAD;
      if (use5) begin
        if (obs5.size() > 0) o = obs5.pop_front();
      end else begin
        if (obs8.size() > 0) o = obs8.pop_front();
      end
      chk({tag, ".event"}, o, e);
    end
    obs8.delete();
    obs5.delete();
  endtask

  // Drive one frame and record its expected outcome.
  task automatic send_frame(input logic [8:0] data, input int pre, input bit pen,
                            input bit ptyp, input bit s2, input bit bad_par,
                            input bit bad_s1, input bit bad_s2,
                            input int glitch_bit, input int gap, input bit scramble);
    int       p;
    int       width;
    int       g;
    logic     bits[$];
    logic     par;
    logic     err_p;
    logic     err_s;
    logic [8:0] d;
    width   = use5 ? 5 : 8;
    p       = (pre < 6) ? 6 : pre;
    pre_in  = 6'(pre);
    pen_in  = pen;
    ptyp_in = ptyp;
    s2_in   = s2;
    d       = data & 9'((1 << width) - 1);
    par     = ptyp;
    bits    = {};
    bits.push_back(1'b0);
    for (int i = 0; i < width; i++) begin
      bits.push_back(d[i]);
      par = par ^ d[i];
    end
    if (pen) bits.push_back(par ^ bad_par);
    bits.push_back(!bad_s1);
    if (s2) bits.push_back(!bad_s2);
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c < p; c++) begin
        if (glitch_bit >= 0 && b == glitch_bit + 1 && c == p / 2 + 1) line = ~bits[b];
        else line = bits[b];
        @(negedge clk);
      end
      if (scramble && b == 0) begin
        pre_in  = 6'($urandom);
        pen_in  = 1'($urandom);
        ptyp_in = 1'($urandom);
        s2_in   = 1'($urandom);
      end
    end
    line = 1'b1;
    g = gap;
    if ((!s2 && bad_s1) || (s2 && bad_s2)) g = (gap > p) ? gap : p + 2;
    repeat (g) @(negedge clk);

    err_p = pen && bad_par;
    err_s = bad_s1 || (s2 && bad_s2);
    if (!err_p && !err_s) begin
      exp_q.push_back(ev(1'b1, 1'b0, 1'b0, d));
      if (use5) lg5 = d; else lg8 = d;
    end else begin
      exp_q.push_back(ev(1'b0, err_p, err_s, use5 ? lg5 : lg8));
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    line    = 1'b1;
    use5    = 1'b0;
    pre_in  = 6'd8;
    pen_in  = 1'b0;
    ptyp_in = 1'b0;
    s2_in   = 1'b0;
    lg8     = '0;
    lg5     = '0;

    repeat (3) @(negedge clk);
    chk("rst.pdata", 32'(pd8), 32'h0);
    chk("rst.valid", 32'(dv8), 32'h0);
    chk("rst.perr",  32'(pe8), 32'h0);
    chk("rst.serr",  32'(se8), 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic 8N1 frame.
    send_frame(9'hA5, 8, 0, 0, 0, 0, 0, 0, -1, 10, 0);
    flush("a5_p8");

    // Even parity: good then corrupted parity bit.
    send_frame(9'h3C, 16, 1, 0, 0, 0, 0, 0, -1, 10, 0);
    send_frame(9'h3C, 16, 1, 0, 0, 1, 0, 0, -1, 10, 0);
    flush("par_even");

    // Two stop bits, second one low.
    send_frame(9'h5A, 16, 0, 0, 1, 0, 0, 1, -1, 10, 0);
    flush("stop2_bad");

    // Short low pulse on an idle line is rejected.
    line = 1'b0;
    repeat (3) @(negedge clk);
    line = 1'b1;
    repeat (40) @(negedge clk);
    flush("start_glitch");
    // Single-cycle glitch at the centre sample of data bit 3.
    send_frame(9'h96, 16, 0, 0, 0, 0, 0, 0, 3, 10, 0);
    flush("data_glitch");

    // Back-to-back frames with no idle time.
    send_frame(9'h55, 32, 0, 0, 0, 0, 0, 0, -1, 0, 0);
    send_frame(9'hAA, 32, 0, 0, 0, 0, 0, 0, -1, 10, 0);
    flush("b2b_p32");

    // Back-to-back at the minimum prescale (requested as 3).
    send_frame(9'hC3, 3, 0, 0, 0, 0, 0, 0, -1, 0, 0);
    send_frame(9'h81, 6, 1, 1, 1, 0, 0, 0, -1, 0, 0);
    send_frame(9'h7E, 6, 0, 0, 0, 0, 0, 0, -1, 10, 0);
    flush("b2b_p6");

    // Reset in the middle of the data phase.
    pre_in = 6'd16;
    pen_in = 1'b0;
    s2_in  = 1'b0;
    line = 1'b0; repeat (16) @(negedge clk);
    line = 1'b1; repeat (16) @(negedge clk);
    line = 1'b0; repeat (8) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstmid.pdata", 32'(pd8), 32'h0);
    chk("rstmid.valid", 32'(dv8), 32'h0);
    chk("rstmid.perr",  32'(pe8), 32'h0);
    chk("rstmid.serr",  32'(se8), 32'h0);
    line = 1'b1;
    repeat (40) @(negedge clk);
    rst_n = 1'b1;
    lg8 = '0;
    lg5 = '0;
    repeat (10) @(negedge clk);
    flush("rstmid_quiet");
    send_frame(9'h0F, 16, 0, 0, 0, 0, 0, 0, -1, 10, 0);
    flush("after_rst");

    // Break: line held low well beyond a frame gives one stop error only.
    pre_in = 6'd8;
    pen_in = 1'b0;
    s2_in  = 1'b0;
    line = 1'b0;
    repeat (200) @(negedge clk);
    line = 1'b1;
    repeat (30) @(negedge clk);
    exp_q.push_back(ev(1'b0, 1'b0, 1'b1, lg8));
    flush("break");
    send_frame(9'h42, 8, 0, 0, 0, 0, 0, 0, -1, 10, 0);
    flush("after_break");

    // Randomised 8-bit frames, config scrambled mid-frame.
    for (int n = 0; n < 30; n++) begin
      send_frame(9'($urandom), $urandom_range(3, 24), 1'($urandom), 1'($urandom),
                 1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 5) == 0), -1, $urandom_range(0, 3), 1'b1);
      if (n % 5 == 4) flush("rand8");
    end

    // 5-bit instance.
    use5 = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(9'h13, 8, 1, 1, 0, 0, 0, 0, -1, 10, 0);
    send_frame(9'h0A, 3, 0, 0, 0, 0, 0, 0, -1, 10, 0);
    flush("w5_directed");
    for (int n = 0; n < 10; n++) begin
      send_frame(9'($urandom), $urandom_range(3, 24), 1'($urandom), 1'($urandom),
                 1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 5) == 0), -1, $urandom_range(0, 3), 1'b1);
      if (n % 5 == 4) flush("rand5");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
